// File: rtl/aes_const.sv
// Constants, types and helpers shared by the AES encrypt/decrypt datapaths.
package aes_const;

   localparam int NB = 4;

   function automatic int nr_of(input int nk);
      return nk + 6;
   endfunction

   function automatic int nw_of(input int nk);
      return NB * (nk + 7);
   endfunction

   typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} fsm_t;

   // Index 0 is the most significant byte, so s[r,c] lives at [r + 4*c].
   typedef logic [0:15][7:0]  blk_t;
   typedef logic [0:3][7:0]   col_t;
   typedef logic [255:0][7:0] tbl_t;

   function automatic logic [7:0] rcon(input int i);
      case (i)
         1:       return 8'h01;
         2:       return 8'h02;
         3:       return 8'h04;
         4:       return 8'h08;
         5:       return 8'h10;
         6:       return 8'h20;
         7:       return 8'h40;
         8:       return 8'h80;
         9:       return 8'h1b;
         10:      return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/aes_imcol.sv
// Combinational InvMixColumns of one state column using the exp/log tables.
import aes_const::*;

module aes_imcol (
   input  tbl_t exp3,
   input  tbl_t ln3,
   input  col_t col,
   output col_t mixed
);

   // Log sum is reduced mod 255, so the exp index stays in 0..254.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] c);
      logic [8:0] s;
      s = {1'b0, ln3[a]} + {1'b0, ln3[c]};
      if (s >= 9'd255) s = s - 9'd255;
      return (a == 8'h00) ? 8'h00 : exp3[s[7:0]];
   endfunction

   always_comb begin
      mixed = '0;
      for (int i = 0; i < 4; i++) begin
         mixed[2'(i)] = gmul(col[2'(i)],     8'h0e) ^ gmul(col[2'(i + 1)], 8'h0b)
                      ^ gmul(col[2'(i + 2)], 8'h0d) ^ gmul(col[2'(i + 3)], 8'h09);
      end
   end

endmodule

// File: rtl/aes_tables.sv
// Shared S-box, inverse S-box and GF(2^8) exp/log (generator 3) tables.
import aes_const::*;

module aes_tables (
   output tbl_t sbox,
   output tbl_t ibox,
   output tbl_t exp3,
   output tbl_t ln3
);

   function automatic tbl_t gen_exp3();
      tbl_t       t = '0;
      logic [7:0] x = 8'h01;
      for (int i = 0; i < 256; i++) begin
         t[8'(i)] = x;
         x = x ^ xtime(x);
      end
      return t;
   endfunction

   function automatic tbl_t gen_ln3();
      tbl_t       t = '0;
      logic [7:0] x = 8'h01;
      for (int i = 0; i < 255; i++) begin
         t[x] = 8'(i);
         x = x ^ xtime(x);
      end
      return t;
   endfunction

   // Multiplicative inverse via the log tables, then the FIPS-197 affine map.
   function automatic tbl_t gen_sbox(input tbl_t e, input tbl_t l);
      tbl_t       t = '0;
      logic [7:0] a, inv;
      for (int i = 0; i < 256; i++) begin
         a   = 8'(i);
         inv = (a == 8'h00) ? 8'h00 : e[8'hff - l[a]];
         t[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
      return t;
   endfunction

   function automatic tbl_t gen_ibox(input tbl_t s);
      tbl_t t = '0;
      for (int i = 0; i < 256; i++) t[s[8'(i)]] = 8'(i);
      return t;
   endfunction

   assign exp3 = gen_exp3();
   assign ln3  = gen_ln3();
   assign sbox = gen_sbox(exp3, ln3);
   assign ibox = gen_ibox(sbox);

endmodule

// File: rtl/aes_dec.sv
// Iterative AES inverse cipher: one key word per cycle, then one round per cycle.
// Define AES_DEC_KEY_CACHE_EN to skip key expansion when the key repeats.
import aes_const::*;

module aes_dec #(
   parameter int NK = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [32*NK-1:0]  key_in,
   input  logic [127:0]      data_in,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [127:0]      data_out,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam int NR   = nr_of(NK);
   localparam int NW   = nw_of(NK);
   localparam int WI_W = $clog2(NW);

   fsm_t                   st, st_nxt;
   blk_t                   blk, isr, x, mixed, rk_cur, rk_last, rk_top;
   logic [0:NW-1][31:0]    w;
   logic [WI_W-1:0]        wi, wi_prev, wi_old, rk_base;
   logic [3:0]             r;
   logic [31:0]            prev, t, new_w;
   logic                   accept, cache_hit, last_word;
   tbl_t                   sbox, ibox, exp3, ln3;

   aes_tables u_tables (.sbox(sbox), .ibox(ibox), .exp3(exp3), .ln3(ln3));

   function automatic logic [31:0] sub_word(input logic [31:0] v);
      return {sbox[v[31:24]], sbox[v[23:16]], sbox[v[15:8]], sbox[v[7:0]]};
   endfunction

   // Key expansion: next word from w[wi-1] and w[wi-NK].
   always_comb begin
      wi_prev = wi - WI_W'(1);
      wi_old  = wi - WI_W'(NK);
      prev    = w[wi_prev];
      if (int'(wi) % NK == 0)
         t = sub_word({prev[23:0], prev[31:24]}) ^ {rcon(int'(wi) / NK), 24'h0};
      else if (NK == 8 && int'(wi) % 8 == 4)
         t = sub_word(prev);
      else
         t = prev;
      new_w = w[wi_old] ^ t;
   end

   assign last_word = (wi == WI_W'(NW - 1));
   assign rk_base   = WI_W'({r, 2'b00});
   assign rk_cur    = {w[rk_base], w[rk_base + WI_W'(1)], w[rk_base + WI_W'(2)], w[rk_base + WI_W'(3)]};
   // The last expanded word is being written this cycle, so take it from new_w.
   assign rk_last   = {w[NW-4], w[NW-3], w[NW-2], new_w};
   assign rk_top    = {w[NW-4], w[NW-3], w[NW-2], w[NW-1]};

   always_comb begin
      isr = '0;
      x   = '0;
      for (int k = 0; k < 16; k++) begin
         isr[4'(k)] = blk[4'(4 * (((k / 4) - (k % 4)) & 3) + (k % 4))];
         x[4'(k)]   = ibox[isr[4'(k)]] ^ rk_cur[4'(k)];
      end
   end

   for (genvar c = 0; c < 4; c++) begin : g_imcol
      aes_imcol u_imcol (
         .exp3 (exp3),
         .ln3  (ln3),
         .col  (x[4*c : 4*c+3]),
         .mixed(mixed[4*c : 4*c+3])
      );
   end

   assign accept = (st == IDLE) && in_valid;

`ifdef AES_DEC_KEY_CACHE_EN
   // w[0..NK-1] hold the key that produced the current expansion.
   logic cache_vld;
   assign cache_hit = cache_vld && (key_in == w[0:NK-1]);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cache_vld <= 1'b0;
      else if (accept && !cache_hit)
         cache_vld <= 1'b0;
      else if (st == KEXP && last_word)
         cache_vld <= 1'b1;
   end
`else
   assign cache_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) st <= IDLE;
      else      st <= st_nxt;
   end

   // NOTE: every path assigns st_nxt via the default first, so no latch is inferred.
   always_comb begin
      st_nxt = st;
      case (st)
         IDLE:    if (in_valid) st_nxt = cache_hit ? ROUND : KEXP;
         KEXP:    if (last_word) st_nxt = ROUND;
         ROUND:   if (r == 4'd0) st_nxt = DONE;
         DONE:    if (out_ready) st_nxt = IDLE;
         default: st_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (st == IDLE);
      out_valid = (st == DONE);
      data_out  = out_valid ? blk : '0;
   end

   // NOTE: the expanded-key array is reset too, so a reused or aborted key never leaks stale words.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         blk <= '0;
         w   <= '0;
         wi  <= '0;
         r   <= '0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values, matching the hardware.
         case (st)
            IDLE: if (accept) begin
               r <= 4'(NR - 1);
               if (cache_hit) begin
                  blk <= data_in ^ rk_top;
               end else begin
                  blk       <= data_in;
                  w[0:NK-1] <= key_in;
                  wi        <= WI_W'(NK);
               end
            end
            KEXP: begin
               w[wi] <= new_w;
               wi    <= wi + WI_W'(1);
               if (last_word) begin
                  blk <= blk ^ rk_last;
                  r   <= 4'(NR - 1);
               end
            end
            ROUND: begin
               blk <= (r == 4'd0) ? x : mixed;
               r   <= r - 4'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_dec.sv
// Directed bench for aes_dec at NK=4/6/8: vectors, backpressure, reset abort, key cache.
module tb_aes_dec;

`ifdef AES_DEC_KEY_CACHE_EN
   localparam int HIT_LAT = 10;
`else
   localparam int HIT_LAT = 50;
`endif

   typedef struct {
      int           sel;
      logic [255:0] key;
      logic [127:0] ct;
      logic [127:0] pt;
      int           lat;
      string        name;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [127:0] k4;
   logic [191:0] k6;
   logic [255:0] k8;
   logic [127:0] din;
   logic [2:0]   iv;
   logic         ordy;
   logic [2:0]   ir, ov;
   logic [127:0] dout [3];

   int   n_checks = 0;
   int   n_fail   = 0;
   vec_t vecs [4];

   always #5 clk = ~clk;

   aes_dec #(.NK(4)) u_dut4 (.clk(clk), .rst(rst), .key_in(k4), .data_in(din), .in_valid(iv[0]),
      .in_ready(ir[0]), .data_out(dout[0]), .out_valid(ov[0]), .out_ready(ordy));
   aes_dec #(.NK(6)) u_dut6 (.clk(clk), .rst(rst), .key_in(k6), .data_in(din), .in_valid(iv[1]),
      .in_ready(ir[1]), .data_out(dout[1]), .out_valid(ov[1]), .out_ready(ordy));
   aes_dec #(.NK(8)) u_dut8 (.clk(clk), .rst(rst), .key_in(k8), .data_in(din), .in_valid(iv[2]),
      .in_ready(ir[2]), .data_out(dout[2]), .out_valid(ov[2]), .out_ready(ordy));

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_in(input int sel, input logic [255:0] key, input logic [127:0] ct, input logic valid);
      k4  = key[127:0];
      k6  = key[191:0];
      k8  = key;
      din = ct;
      iv  = valid ? 3'(1 << sel) : 3'b000;
   endtask

   // Ends on the falling edge right after the accept edge, with inputs scrambled.
   task automatic start(input vec_t v);
      set_in(v.sel, v.key, v.ct, 1'b1);
      @(posedge clk);
      @(negedge clk);
      set_in(v.sel, ~v.key, ~v.ct, 1'b0);
   endtask

   task automatic wait_out(input int sel, output int lat);
      lat = 0;
      while (!ov[sel] && lat < 300) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
   endtask

   task automatic handshake(input int sel, input string name);
      ordy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ordy = 1'b0;
      check({name, " in_ready after out handshake"}, 256'(ir[sel]), 256'(1));
      check({name, " out_valid after out handshake"}, 256'(ov[sel]), 256'(0));
   endtask

   task automatic run_vec(input vec_t v);
      int lat;
      start(v);
      wait_out(v.sel, lat);
      check({v.name, " latency"}, 256'(lat), 256'(v.lat));
      check({v.name, " data_out"}, 256'(dout[v.sel]), 256'(v.pt));
      handshake(v.sel, v.name);
   endtask

   initial begin
      vec_t v;
      int   lat;
      int   bad;

      vecs[0] = '{0, 256'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
                  128'h3243f6a8885a308d313198a2e0370734, 50, "fips_nk4"};
      vecs[1] = '{0, 256'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                  128'h00112233445566778899aabbccddeeff, 50, "seq_nk4"};
      vecs[2] = '{1, 256'h000102030405060708090a0b0c0d0e0f1011121314151617,
                  128'hdda97ca4864cdfe06eaf70a0ec0d7191, 128'h00112233445566778899aabbccddeeff, 58, "seq_nk6"};
      vecs[3] = '{2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                  128'h8ea2b7ca516745bfeafc49904b496089, 128'h00112233445566778899aabbccddeeff, 66, "seq_nk8"};

      set_in(0, '0, '0, 1'b0);
      ordy = 1'b0;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         check("reset out_valid", 256'(ov[s]), 256'(0));
         check("reset data_out", 256'(dout[s]), 256'(0));
      end
      rst = 1'b1;
      @(negedge clk);
      for (int s = 0; s < 3; s++) check("in_ready after reset", 256'(ir[s]), 256'(1));

      for (int i = 0; i < 4; i++) run_vec(vecs[i]);

      // Same key twice on NK=4, then a changed key.
      v = vecs[1];
      v.lat  = HIT_LAT;
      v.name = "cache_same_key";
      run_vec(v);
      v = vecs[0];
      v.name = "cache_new_key";
      run_vec(v);

      // Backpressure: result held, in_valid pulse with other data ignored.
      start(vecs[0]);
      wait_out(0, lat);
      check("bp reached out_valid", 256'(ov[0]), 256'(1));
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         if (c == 5) set_in(0, vecs[1].key, vecs[1].ct, 1'b1);
         if (c == 6) set_in(0, vecs[1].key, vecs[1].ct, 1'b0);
         @(posedge clk);
         @(negedge clk);
         if (dout[0] !== vecs[0].pt || ov[0] !== 1'b1 || ir[0] !== 1'b0) bad++;
      end
      check("bp held cycles with bad outputs", 256'(bad), 256'(0));
      handshake(0, "bp");
      repeat (5) @(negedge clk);
      check("bp pulse ignored", 256'(ov[0]), 256'(0));

      // Reset 30 cycles into key expansion, then a clean full-latency block.
      start(vecs[1]);
      repeat (30) @(negedge clk);
      check("mid kexp out_valid", 256'(ov[0]), 256'(0));
      #2 rst = 1'b0;
      #1;
      check("async reset out_valid", 256'(ov[0]), 256'(0));
      check("async reset data_out", 256'(dout[0]), 256'(0));
      check("async reset in_ready", 256'(ir[0]), 256'(1));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      v = vecs[1];
      v.name = "after_reset";
      run_vec(v);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/aes_dec.md
# aes_dec

Iterative AES inverse cipher (FIPS-197 InvCipher) that recovers plaintext from a 128-bit ciphertext block. It sits beside the encryption datapath, sharing its constants, S-box/inverse-S-box and GF(2^8) log/exp tables. It accepts a key and block through a valid/ready handshake and expands the key one word per cycle. It then runs one inverse round per cycle and holds the result until the consumer takes it.

## Interface
- NK, 4, key length in 32-bit words (4, 6 or 8); NR = NK+6 rounds, NW = 4*(NR+1) expanded words
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- key_in  in  32*NK  cipher key, byte 0 in MSBs
- data_in  in  128  ciphertext, byte 0 in [127:120], state s[r,c] = byte[r+4c]
- in_valid  in  1  key_in/data_in valid
- in_ready  out  1  block can accept
- data_out  out  128  plaintext, same byte order
- out_valid  out  1  data_out valid
- out_ready  in  1  consumer accepts data_out

## Operation
- FSM states: IDLE, KEXP, ROUND, DONE.
- IDLE
  - in_ready=1.
  - On in_valid&&in_ready: latch the block; load words w[0..NK-1] from key_in; set word index wi=NK; go to KEXP.
- KEXP: one word per cycle.
  - Base rule: w[wi] = w[wi-NK] ^ t, with t = w[wi-1].
  - If wi%NK==0: t = SubWord(RotWord(w[wi-1])) ^ Rcon[wi/NK].
  - If NK==8 and wi%8==4: t = SubWord(w[wi-1]).
  - On the cycle writing wi=NW-1: state <= block ^ roundkey(NR); r <= NR-1; go to ROUND.
- ROUND: one round per cycle.
  - Compute x = InvSubBytes(InvShiftRows(state)) ^ roundkey(r).
  - If r>=1: state <= InvMixColumns(x). If r==0: state <= x and go to DONE.
  - Decrement r each cycle.
- DONE
  - out_valid=1; data_out = state, stable until handshake.
  - On out_ready: go to IDLE.
  - in_ready is 0 in DONE: no overlap of output handshake and new accept.
- roundkey(r) = {w[4r], w[4r+1], w[4r+2], w[4r+3]}. The word's MSB byte is row 0.
- Arithmetic
  - All GF(2^8) multiplies by 09/0B/0D/0E use the shared EXP/LN tables.
  - A zero operand yields 0.
  - Table indices are mod 255 and never reach 255.
- Boundary behaviour
  - in_valid is ignored outside IDLE. Changes to key_in/data_in after accept have no effect.
  - out_ready while out_valid=0 has no effect.

## Timing
- Reset values
  - state=IDLE; in_ready=1 from the first cycle after reset release.
  - out_valid=0, data_out=0.
  - Expanded-key registers and counters are 0.
- Latency (accept edge to out_valid high)
  - Full expansion: (NW-NK) + NR cycles: 50 for NK=4, 58 for NK=6, 66 for NK=8.
  - Cache hit: NR cycles (see Configuration).
- After the out handshake edge, in_ready=1 in the next cycle.
- Minimum throughput: one block per latency+2 cycles.
- Reset asserted mid-operation:
  - Returns to IDLE immediately; out_valid drops asynchronously.
  - The in-flight block is discarded; the key cache is invalidated.

## Configuration
- AES_DEC_KEY_CACHE_EN defined:
  - Keep the expanded key and a copy of the last expanded key_in plus a cache-valid bit.
  - On accept with key_in equal to the stored key and the valid bit set: skip KEXP, load state <= block ^ roundkey(NR), go straight to ROUND.
  - Latency on a hit is NR cycles.
- Undefined: every accepted block performs full KEXP; no comparator or stored key copy is built.

## Structure
- Shared package aes_const holds:
  - Nb, Nk, Nr-derived constants;
  - the FSM state enum typedef;
  - a 16-byte state array typedef;
  - Rcon.
- SBox, IBox, EXP3 and LN3 come from the existing table module, instantiated once.
- Sub-module aes_imcol: combinational InvMixColumns on one 4-byte column using the EXP/LN tables, instantiated 4 times.
- InvShiftRows and InvSubBytes are inline.

## Test plan
- NK=4: key 2b7e151628aed2a6abf7158809cf4f3c, data_in 3925841d02dc09fbdc118597196a0b32 -> data_out 3243f6a8885a308d313198a2e0370734, out_valid exactly 50 cycles after accept.
- NK=4/6/8, key 000102…(NK*4 bytes) -> data_out 00112233445566778899aabbccddeeff:
  - NK=4: ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a;
  - NK=6: ciphertext dda97ca4864cdfe06eaf70a0ec0d7191;
  - NK=8: ciphertext 8ea2b7ca516745bfeafc49904b496089.
- Backpressure: hold out_ready=0 for 20 cycles -> data_out stable, out_valid held, in_ready=0. Pulse in_valid with other data meanwhile -> ignored.
- Reset at cycle 30 of KEXP -> outputs at reset values; a following block decrypts correctly with full latency.
- Key cache, with AES_DEC_KEY_CACHE_EN:
  - Two back-to-back blocks, same key -> second out_valid after 10 cycles.
  - Changed key -> 50 cycles.
  - Without the macro -> 50 cycles both times.
